sc_bottomsidedetector: RTL



---
 rtl/sc_bottomsidedetector.sv | 118 +++++++++++
 1 files changed

// File: rtl/sc_bottomsidedetector.sv
// ============================================================================
// Module   : sc_bottomsidedetector
// Brief    : Debounced row-condition detector with a level output, a rise pulse
//            and an optional saturating event counter
//            (SC_BOTTOMSIDEDETECTOR_EVCOUNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_bottomsidedetector #(
  parameter int DATAWIDTH    = 8,
  parameter int HOLDCYCLES   = 2,
  parameter int EVCOUNTWIDTH = 4
) (
  input  logic                    SC_BOTTOMSIDEDETECTOR_CLOCK_50,
  input  logic                    SC_BOTTOMSIDEDETECTOR_RESET_InHigh,
  input  logic                    SC_BOTTOMSIDEDETECTOR_enable_InHigh,
  input  logic [1:0]              SC_BOTTOMSIDEDETECTOR_mode_InBUS,
  input  logic [DATAWIDTH-1:0]    SC_BOTTOMSIDEDETECTOR_pattern_InBUS,
  input  logic [DATAWIDTH-1:0]    SC_BOTTOMSIDEDETECTOR_data_InBUS,
  input  logic                    SC_BOTTOMSIDEDETECTOR_clear_InHigh,
  output logic                    SC_BOTTOMSIDEDETECTOR_bottomside_OutHigh,
  output logic                    SC_BOTTOMSIDEDETECTOR_bottomsidePulse_OutHigh,
  output logic [EVCOUNTWIDTH-1:0] SC_BOTTOMSIDEDETECTOR_eventCount_OutBUS
);

  localparam int              c_HW   = $clog2(HOLDCYCLES + 1);
  localparam logic [c_HW-1:0] c_HOLD = c_HW'(HOLDCYCLES);

  localparam logic [1:0] c_ST_IDLE     = 2'd0;
  localparam logic [1:0] c_ST_ARMING   = 2'd1;
  localparam logic [1:0] c_ST_DETECTED = 2'd2;

  logic            w_cond;
  logic            w_match;
  logic            w_mode_chg;
  logic            w_enter;
  logic [c_HW-1:0] w_hold_nxt;
  logic [1:0]      w_state_nxt;
  logic [c_HW-1:0] r_hold;
  logic [1:0]      r_state;
  logic [1:0]      r_mode;
  logic            r_pulse;

  always_comb begin
    w_cond = 1'b0;
    case (SC_BOTTOMSIDEDETECTOR_mode_InBUS)
      2'b00:   w_cond = (SC_BOTTOMSIDEDETECTOR_data_InBUS == '0);
      2'b01:   w_cond = (SC_BOTTOMSIDEDETECTOR_data_InBUS == {DATAWIDTH{1'b1}});
      2'b10:   w_cond = (SC_BOTTOMSIDEDETECTOR_data_InBUS == SC_BOTTOMSIDEDETECTOR_pattern_InBUS);
      default: w_cond = (SC_BOTTOMSIDEDETECTOR_data_InBUS != SC_BOTTOMSIDEDETECTOR_pattern_InBUS);
    endcase
  end

  assign w_match    = SC_BOTTOMSIDEDETECTOR_enable_InHigh & w_cond;
  assign w_mode_chg = (SC_BOTTOMSIDEDETECTOR_mode_InBUS != r_mode);

  // A mode change restarts the debounce even if the new condition already holds
  always_comb begin
    w_hold_nxt = '0;
    if (!w_mode_chg && w_match) begin
      w_hold_nxt = (r_hold == c_HOLD) ? c_HOLD : r_hold + c_HW'(1);
    end
  end

  always_comb begin
    w_state_nxt = c_ST_ARMING;
    if (w_hold_nxt == '0) begin
      w_state_nxt = c_ST_IDLE;
    end else if (w_hold_nxt == c_HOLD) begin
      w_state_nxt = c_ST_DETECTED;
    end
  end

  assign w_enter = (w_state_nxt == c_ST_DETECTED) && (r_state != c_ST_DETECTED);

  always_ff @(posedge SC_BOTTOMSIDEDETECTOR_CLOCK_50) begin
    if (SC_BOTTOMSIDEDETECTOR_RESET_InHigh) begin
      r_hold  <= '0;
      r_state <= c_ST_IDLE;
      r_mode  <= SC_BOTTOMSIDEDETECTOR_mode_InBUS;
      r_pulse <= 1'b0;
    end else begin
      r_hold  <= w_hold_nxt;
      r_state <= w_state_nxt;
      r_mode  <= SC_BOTTOMSIDEDETECTOR_mode_InBUS;
      r_pulse <= w_enter;
    end
  end

  assign SC_BOTTOMSIDEDETECTOR_bottomside_OutHigh      = (r_state == c_ST_DETECTED);
  assign SC_BOTTOMSIDEDETECTOR_bottomsidePulse_OutHigh = r_pulse;

`ifdef SC_BOTTOMSIDEDETECTOR_EVCOUNT_EN
  logic [EVCOUNTWIDTH-1:0] r_evcount;

  // Clear coinciding with a new detection keeps that detection as the first count
  always_ff @(posedge SC_BOTTOMSIDEDETECTOR_CLOCK_50) begin
    if (SC_BOTTOMSIDEDETECTOR_RESET_InHigh) begin
      r_evcount <= '0;
    end else if (SC_BOTTOMSIDEDETECTOR_clear_InHigh) begin
      r_evcount <= w_enter ? EVCOUNTWIDTH'(1) : '0;
    end else if (w_enter && (r_evcount != {EVCOUNTWIDTH{1'b1}})) begin
      r_evcount <= r_evcount + EVCOUNTWIDTH'(1);
    end
  end

  assign SC_BOTTOMSIDEDETECTOR_eventCount_OutBUS = r_evcount;
`else
  logic w_unused_clear;

  assign w_unused_clear = SC_BOTTOMSIDEDETECTOR_clear_InHigh;
  assign SC_BOTTOMSIDEDETECTOR_eventCount_OutBUS = '0;
`endif

endmodule

`default_nettype wire
